// File: rtl/linex_mode_sequencer.sv
// Line-multiplier mode-change sequencer in the VCLK_Tx domain: mutes video,
// waits for a frame boundary, retargets the Tx PLL and unmutes once settled.
module linex_mode_sequencer #(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned PLL_RST_CYC   = 8,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned VS_TIMEOUT    = 2000000
) (
  input  logic       VCLK_Tx,
  input  logic       VRST_Tx,
  input  logic [1:0] cfg_req_i,
  input  logic       vdata_valid_i,
  input  logic       nVSYNC_i,
  input  logic       pll_locked_i,
  output logic [1:0] cfg_act_o,
  output logic [1:0] pll_sel_o,
  output logic       pll_rst_o,
  output logic       mute_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUTE,
    ST_SWITCH,
    ST_WAIT_LOCK,
    ST_SETTLE
  } state_t;

  localparam logic [1:0]  MODE_X1     = 2'b00;
  localparam logic [1:0]  MODE_X2     = 2'b01;
  localparam logic [1:0]  MODE_X3     = 2'b10;
  localparam logic [21:0] VS_LAST     = 22'(VS_TIMEOUT - 1);
  localparam logic [21:0] LOCK_LAST   = 22'(LOCK_TIMEOUT - 1);
  localparam logic [21:0] RST_LAST    = 22'(PLL_RST_CYC - 1);
  localparam logic [3:0]  FRAMES_LAST = 4'(SETTLE_FRAMES - 1);

  state_t      state, state_nx;
  logic [1:0]  target, target_nx;
  logic [1:0]  cfg_act, cfg_act_nx;
  logic [1:0]  req_raw_d, req_n, req_n_d;
  logic        timeout_q, timeout_nx;
  logic        block_q, block_nx;
  logic        pll_rst_q;
  logic        vs_d, frame_edge;
  logic        lock_s1, lock_s2;
  logic [1:0]  lock_run;
  logic [21:0] dwell_cnt;
  logic [3:0]  frame_cnt;
  logic        req_go, lock_ok;

  assign req_n      = (cfg_req_i == 2'b11) ? MODE_X2 : cfg_req_i;
  assign req_n_d    = (req_raw_d == 2'b11) ? MODE_X2 : req_raw_d;
  assign frame_edge = vdata_valid_i & vs_d & ~nVSYNC_i;
  assign lock_ok    = lock_s2 && (lock_run == 2'd2);

  // After a lock timeout a still-held x3 request stays blocked until cfg_req_i moves.
  assign req_go = (req_n == req_n_d) && (req_n != cfg_act)
                  && !(block_q && (req_n == MODE_X3));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    target_nx  = target;
    cfg_act_nx = cfg_act;
    timeout_nx = timeout_q;
    block_nx   = block_q;
    if (cfg_req_i != req_raw_d) block_nx = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (req_go) begin
          state_nx  = ST_MUTE;
          target_nx = req_n;
        end
      end
      ST_MUTE: begin
        target_nx = req_n;
        if (frame_edge || (dwell_cnt == VS_LAST)) begin
          state_nx   = ST_SWITCH;
          cfg_act_nx = req_n;
        end
      end
      ST_SWITCH: begin
        if (dwell_cnt == RST_LAST)
          state_nx = (target == MODE_X3) ? ST_WAIT_LOCK : ST_SETTLE;
      end
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_nx   = ST_SETTLE;
          timeout_nx = 1'b0;
        end else if (dwell_cnt == LOCK_LAST) begin
          state_nx   = ST_SWITCH;
          timeout_nx = 1'b1;
          block_nx   = 1'b1;
          target_nx  = MODE_X2;
          cfg_act_nx = MODE_X2;
        end
      end
      ST_SETTLE: begin
        if (req_go) begin
          state_nx  = ST_MUTE;
          target_nx = req_n;
        end else if (frame_edge && (frame_cnt == FRAMES_LAST)) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_SETTLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high; it is only seen at a VCLK_Tx edge.
  always_ff @(posedge VCLK_Tx) begin
    if (VRST_Tx) begin
      state     <= ST_SETTLE;
      target    <= MODE_X1;
      cfg_act   <= MODE_X1;
      timeout_q <= 1'b0;
      block_q   <= 1'b0;
      pll_rst_q <= 1'b0;
      req_raw_d <= MODE_X1;
      vs_d      <= 1'b0;
      lock_s1   <= 1'b0;
      lock_s2   <= 1'b0;
      lock_run  <= '0;
      dwell_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      state     <= state_nx;
      target    <= target_nx;
      cfg_act   <= cfg_act_nx;
      timeout_q <= timeout_nx;
      block_q   <= block_nx;
      pll_rst_q <= (state_nx == ST_SWITCH);
      req_raw_d <= cfg_req_i;
      lock_s1   <= pll_locked_i;
      lock_s2   <= lock_s1;
      if (vdata_valid_i) vs_d <= nVSYNC_i;

      // One dwell counter serves MUTE, SWITCH and WAIT_LOCK; any state change restarts it.
      if (state_nx != state)
        dwell_cnt <= '0;
      else if (state inside {ST_MUTE, ST_SWITCH, ST_WAIT_LOCK})
        dwell_cnt <= dwell_cnt + 22'd1;

      if (state_nx != state)
        frame_cnt <= '0;
      else if ((state == ST_SETTLE) && frame_edge)
        frame_cnt <= frame_cnt + 4'd1;

      if ((state != ST_WAIT_LOCK) || !lock_s2)
        lock_run <= '0;
      else if (lock_run != 2'd3)
        lock_run <= lock_run + 2'd1;
    end
  end

  assign cfg_act_o = cfg_act;
  assign pll_sel_o = cfg_act;
  assign pll_rst_o = pll_rst_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state != ST_IDLE);
  // Mute rises combinationally in the IDLE cycle that accepts a request.
  assign mute_o    = !((state == ST_IDLE) && !req_go);

endmodule

// File: tb/tb_linex_mode_sequencer.sv
// Bench for linex_mode_sequencer: a rule-level reference model checked every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_linex_mode_sequencer;

  localparam int SETTLE_F = 2;
  localparam int RST_CYC  = 8;
  localparam int LOCK_TO  = 1000;
  localparam int VS_TO    = 500;
  localparam int FRAME_P  = 120;

  localparam int P_IDLE   = 0;
  localparam int P_MUTE   = 1;
  localparam int P_SWITCH = 2;
  localparam int P_WAIT   = 3;
  localparam int P_SETTLE = 4;

  logic       VCLK_Tx = 1'b0;
  logic       VRST_Tx;
  logic [1:0] cfg_req_i;
  logic       vdata_valid_i;
  logic       nVSYNC_i;
  logic       pll_locked_i;
  logic [1:0] cfg_act_o;
  logic [1:0] pll_sel_o;
  logic       pll_rst_o;
  logic       mute_o;
  logic       busy_o;
  logic       timeout_o;

  linex_mode_sequencer #(
    .SETTLE_FRAMES(SETTLE_F),
    .PLL_RST_CYC  (RST_CYC),
    .LOCK_TIMEOUT (LOCK_TO),
    .VS_TIMEOUT   (VS_TO)
  ) dut (
    .VCLK_Tx      (VCLK_Tx),
    .VRST_Tx      (VRST_Tx),
    .cfg_req_i    (cfg_req_i),
    .vdata_valid_i(vdata_valid_i),
    .nVSYNC_i     (nVSYNC_i),
    .pll_locked_i (pll_locked_i),
    .cfg_act_o    (cfg_act_o),
    .pll_sel_o    (pll_sel_o),
    .pll_rst_o    (pll_rst_o),
    .mute_o       (mute_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 VCLK_Tx = ~VCLK_Tx;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  int         entered = 0;
  int         frames_seen = 0;
  int         lock_streak = 0;
  int         fe_total = 0;
  int         last_fe_pulse = -100;
  int         e_phase = P_SETTLE;
  logic [1:0] e_act = 2'b00;
  logic [1:0] e_tgt = 2'b00;
  bit         e_to = 1'b0;
  bit         e_block = 1'b0;
  bit         m_on = 1'b0;
  logic       m_vs_last = 1'b0;
  logic [1:0] m_raw_last = 2'b00;
  logic [4:0] m_lk = '0;

  function automatic logic [1:0] norm(input logic [1:0] r);
    return (r == 2'b11) ? 2'b01 : r;
  endfunction

  // A request counts when it held its value across an edge, differs from the
  // applied mode, and is not the x3 request parked after a lock failure.
  function automatic bit m_want();
    return (norm(cfg_req_i) == norm(m_raw_last)) && (norm(cfg_req_i) != e_act)
           && !(e_block && (norm(cfg_req_i) == 2'b10));
  endfunction

  task automatic enter(input int p);
    e_phase     = p;
    entered     = cyc;
    frames_seen = 0;
    lock_streak = 0;
  endtask

  initial begin : model
    bit         fe, want, sync_lk;
    logic [1:0] rq;
    forever begin
      @(posedge VCLK_Tx);
      cyc++;
      fe      = vdata_valid_i && m_vs_last && !nVSYNC_i;
      want    = m_want();
      rq      = norm(cfg_req_i);
      sync_lk = m_lk[1];
      if (VRST_Tx) begin
        m_on = 1'b1;
        enter(P_SETTLE);
        e_act = 2'b00; e_tgt = 2'b00; e_to = 1'b0; e_block = 1'b0;
        m_vs_last = 1'b0; m_raw_last = 2'b00; m_lk = '0;
      end else begin
        if (fe) begin
          fe_total++;
          last_fe_pulse = cyc - 1;
        end
        if (cfg_req_i != m_raw_last) e_block = 1'b0;
        case (e_phase)
          P_IDLE: if (want) begin e_tgt = rq; enter(P_MUTE); end
          P_MUTE: begin
            e_tgt = rq;
            if (fe || (cyc - entered == VS_TO)) begin
              e_act = rq;
              enter(P_SWITCH);
            end
          end
          P_SWITCH:
            if (cyc - entered == RST_CYC) enter((e_tgt == 2'b10) ? P_WAIT : P_SETTLE);
          P_WAIT: begin
            lock_streak = sync_lk ? lock_streak + 1 : 0;
            if (lock_streak >= 3) begin
              e_to = 1'b0;
              enter(P_SETTLE);
            end else if (cyc - entered == LOCK_TO) begin
              e_to = 1'b1; e_block = 1'b1; e_tgt = 2'b01; e_act = 2'b01;
              enter(P_SWITCH);
            end
          end
          default: begin
            if (want) begin
              e_tgt = rq;
              enter(P_MUTE);
            end else if (fe) begin
              frames_seen++;
              if (frames_seen == SETTLE_F) enter(P_IDLE);
            end
          end
        endcase
        if (vdata_valid_i) m_vs_last = nVSYNC_i;
        m_raw_last = cfg_req_i;
        m_lk = {m_lk[3:0], pll_locked_i};
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge VCLK_Tx);
      if (m_on) begin
        check("cfg_act",   32'(cfg_act_o), 32'(e_act));
        check("pll_sel",   32'(pll_sel_o), 32'(e_act));
        check("pll_rst",   32'(pll_rst_o), 32'(e_phase == P_SWITCH));
        check("mute",      32'(mute_o),    32'((e_phase != P_IDLE) || m_want()));
        check("busy",      32'(busy_o),    32'(e_phase != P_IDLE));
        check("timeout",   32'(timeout_o), 32'(e_to));
      end
    end
  end

  // ---------------- frame generator ----------------
  bit vs_en = 1'b1;
  int fcnt = 0;

  initial begin : frames
    nVSYNC_i      = 1'b1;
    vdata_valid_i = 1'b1;
    forever begin
      @(posedge VCLK_Tx);
      #1;
      fcnt++;
      vdata_valid_i = (fcnt % 7) != 3;
      nVSYNC_i      = !(vs_en && ((fcnt % FRAME_P) < 3));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_sig(input string what, input int sel, input logic val,
                          input int bound, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge VCLK_Tx);
      case (sel)
        0:       s = mute_o;
        1:       s = busy_o;
        default: s = pll_rst_o;
      endcase
      if (s === val) begin
        at = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_%s: never reached %0b within %0d cycles", what, val, bound);
  endtask

  task automatic drive_req(input logic [1:0] v);
    @(posedge VCLK_Tx);
    #1;
    cfg_req_i = v;
  endtask

  initial begin : stim
    int t, t0, t2, tr, tf, fe0, busy_hi;
    VRST_Tx      = 1'b1;
    cfg_req_i    = 2'b00;
    pll_locked_i = 1'b0;
    repeat (3) @(posedge VCLK_Tx);
    #1;
    VRST_Tx = 1'b0;

    // Reset release at x1: muted through two frame edges, unmuted the next cycle.
    @(negedge VCLK_Tx);
    check("rst_mute", 32'(mute_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd1);
    fe0 = fe_total;
    wait_sig("unmute0", 0, 1'b0, 1000, t);
    check("init_frames", 32'(fe_total - fe0), 32'd2);
    check("init_unmute_lat", 32'(t - last_fe_pulse), 32'd1);
    check("init_busy", 32'(busy_o), 32'd0);
    check("init_act", 32'(cfg_act_o), 32'd0);

    // x1 -> x2.
    drive_req(2'b01);
    t0 = cyc;
    wait_sig("mute_x2", 0, 1'b1, 3, t);
    check("mute_le3", 32'((t - t0) <= 3), 32'd1);
    wait_sig("rst_x2", 2, 1'b1, 700, t);
    check("sel_x2", 32'(pll_sel_o), 32'd1);
    check("sel_lat", 32'(t - last_fe_pulse), 32'd1);
    wait_sig("rstfall_x2", 2, 1'b0, 20, t2);
    check("rst_len_x2", 32'(t2 - t), 32'd8);
    fe0 = fe_total;
    wait_sig("unmute_x2", 0, 1'b0, 1000, t);
    check("settle_frames_x2", 32'(fe_total - fe0), 32'd2);
    check("act_x2", 32'(cfg_act_o), 32'd1);

    // x2 -> x3, lock arrives 100 cycles after the PLL reset ends.
    drive_req(2'b10);
    wait_sig("rst_x3", 2, 1'b1, 700, t);
    check("sel_x3", 32'(pll_sel_o), 32'd2);
    wait_sig("rstfall_x3", 2, 1'b0, 20, t);
    repeat (100) @(posedge VCLK_Tx);
    #1;
    pll_locked_i = 1'b1;
    wait_sig("unmute_x3", 0, 1'b0, 1000, t);
    check("act_x3", 32'(cfg_act_o), 32'd2);
    check("to_x3", 32'(timeout_o), 32'd0);

    // Back to x1, then x3 with no lock: fallback to x2 and no retry.
    pll_locked_i = 1'b0;
    drive_req(2'b00);
    wait_sig("busy_x1", 1, 1'b1, 10, t);
    wait_sig("unmute_x1", 0, 1'b0, 1000, t);
    drive_req(2'b10);
    wait_sig("rst_nl", 2, 1'b1, 700, t);
    wait_sig("rstfall_nl", 2, 1'b0, 20, tf);
    wait_sig("rst_fb", 2, 1'b1, 1100, tr);
    check("lock_timeout_len", 32'(tr - tf), 32'd1000);
    check("to_set", 32'(timeout_o), 32'd1);
    check("act_fb", 32'(cfg_act_o), 32'd1);
    wait_sig("rstfall_fb", 2, 1'b0, 20, t2);
    check("rst_len_fb", 32'(t2 - tr), 32'd8);
    wait_sig("unmute_fb", 0, 1'b0, 1000, t);
    check("act_idle_fb", 32'(cfg_act_o), 32'd1);
    busy_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge VCLK_Tx);
      if (busy_o !== 1'b0) busy_hi++;
    end
    check("no_retry", 32'(busy_hi), 32'd0);

    // No vsync activity: MUTE is forced out after VS_TO cycles.
    vs_en = 1'b0;
    repeat (5) @(posedge VCLK_Tx);
    drive_req(2'b00);
    wait_sig("busy_vs", 1, 1'b1, 10, t);
    wait_sig("rst_vs", 2, 1'b1, 700, tr);
    check("vs_timeout_len", 32'(tr - t), 32'd500);
    check("act_vs", 32'(cfg_act_o), 32'd0);
    vs_en = 1'b1;
    wait_sig("unmute_vs", 0, 1'b0, 1000, t);

    // Reset during WAIT_LOCK aborts to the reset values (timeout_o is still set here).
    check("to_before_rst", 32'(timeout_o), 32'd1);
    drive_req(2'b10);
    wait_sig("rst_wl", 2, 1'b1, 700, t);
    wait_sig("rstfall_wl", 2, 1'b0, 20, t);
    repeat (50) @(posedge VCLK_Tx);
    #1;
    VRST_Tx = 1'b1;
    @(posedge VCLK_Tx);
    #1;
    VRST_Tx = 1'b0;
    @(negedge VCLK_Tx);
    check("abort_act", 32'(cfg_act_o), 32'd0);
    check("abort_pll_rst", 32'(pll_rst_o), 32'd0);
    check("abort_mute", 32'(mute_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd1);
    check("abort_to", 32'(timeout_o), 32'd0);
    pll_locked_i = 1'b1;
    wait_sig("unmute_rel", 0, 1'b0, 2000, t);
    check("act_rel", 32'(cfg_act_o), 32'd2);

    // Request changes to 11 while muted: treated as x2 and re-latched.
    drive_req(2'b00);
    wait_sig("busy_rl", 1, 1'b1, 10, t);
    repeat (3) @(negedge VCLK_Tx);
    drive_req(2'b11);
    wait_sig("unmute_rl", 0, 1'b0, 2000, t);
    check("act_11", 32'(cfg_act_o), 32'd1);

    repeat (5) @(negedge VCLK_Tx);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #(600000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
